// File: rtl/apb_fifo_pkg.sv
// Shared register offsets, field positions and access-FSM states for the
// APB FIFO register block.
package apb_fifo_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_UDF   = 3;
  localparam int ST_LVL   = 8;

  localparam int CT_FLUSH   = 0;
  localparam int CT_IRQ_EN  = 1;
  localparam int CT_CLR_ERR = 2;
  localparam int CT_THRESH  = 8;

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output and an explicit level counter.
// Flush resets the pointers and level only; the storage array keeps its contents.
module sync_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int LVL_W  = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so wrap is free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        level <= level + 1'b1;
      end else if (do_pop && !do_push) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_fifo_regs.sv
// APB3 slave fronting sync_fifo: DATA push/pop, STATUS flags, CTRL flush/threshold/irq.
// Good DATA reads take one wait state so that PRDATA comes from a register.
module apb_fifo_regs
  import apb_fifo_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic        PREADY,
  output logic [31:0] PRDATA,
  output logic        PSLVERR,
  output logic        irq
);

  state_t             state;
  logic               ovf;
  logic               udf;
  logic               irq_en;
  logic [7:0]         thresh;
  logic [DATA_W-1:0]  rdata_q;

  logic [DATA_W-1:0]  head;
  logic               full;
  logic               empty;
  logic [LVL_W-1:0]   level;

  logic [3:0]         offset;
  logic               addr_ok;
  logic               is_data;
  logic               is_status;
  logic               is_ctrl;
  logic               access;
  logic               wr_full;
  logic               rd_empty;
  logic               err;
  logic               rd_start;
  logic               push;
  logic               ctrl_wr;
  logic               flush;
  logic [31:0]        status_val;
  logic [31:0]        ctrl_val;

  assign offset    = PADDR[3:0];
  assign addr_ok   = ~|PADDR[31:4];
  assign is_data   = addr_ok & (offset == ADDR_DATA);
  assign is_status = addr_ok & (offset == ADDR_STATUS);
  assign is_ctrl   = addr_ok & (offset == ADDR_CTRL);
  assign access    = PSEL & PENABLE & (state == IDLE);

  assign wr_full   = is_data & PWRITE & full;
  assign rd_empty  = is_data & ~PWRITE & empty;
  assign err       = ~(is_data | is_status | is_ctrl) | (is_status & PWRITE) | wr_full | rd_empty;

  assign rd_start  = access & is_data & ~PWRITE & ~err;
  assign push      = access & is_data & PWRITE & ~err;
  assign ctrl_wr   = access & is_ctrl & PWRITE;
  assign flush     = ctrl_wr & PWDATA[CT_FLUSH];

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (PCLK),
    .rst_n (PRESET),
    .push  (push),
    .pop   (rd_start),
    .flush (flush),
    .wdata (PWDATA[DATA_W-1:0]),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    status_val               = '0;
    status_val[ST_EMPTY]     = empty;
    status_val[ST_FULL]      = full;
    status_val[ST_OVF]       = ovf;
    status_val[ST_UDF]       = udf;
    status_val[ST_LVL +: 8]  = 8'(level);
    ctrl_val                 = '0;
    ctrl_val[CT_IRQ_EN]      = irq_en;
    ctrl_val[CT_THRESH +: 8] = thresh;
  end

  // Bus outputs: RESP serves the latched head; IDLE answers everything else directly.
  always_comb begin
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    if (state == RESP) begin
      PREADY = 1'b1;
      if (!PWRITE) begin
        PRDATA = 32'(rdata_q);
      end
    end else begin
      PREADY  = PSEL & PENABLE & ~rd_start;
      PSLVERR = PREADY & err;
      if (PREADY && !PWRITE && !err) begin
        if (is_status) begin
          PRDATA = status_val;
        end else if (is_ctrl) begin
          PRDATA = ctrl_val;
        end
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state   <= IDLE;
      ovf     <= 1'b0;
      udf     <= 1'b0;
      irq_en  <= 1'b0;
      thresh  <= '0;
      rdata_q <= '0;
      irq     <= 1'b0;
    end else begin
      irq <= irq_en & (32'(level) >= 32'(thresh)) & ~empty;

      unique case (state)
        IDLE: begin
          if (rd_start) begin
            rdata_q <= head;
            state   <= RESP;
          end
        end
        RESP: state <= IDLE;
      endcase

      if (access && wr_full) begin
        ovf <= 1'b1;
      end
      if (access && rd_empty) begin
        udf <= 1'b1;
      end
      if (ctrl_wr) begin
        irq_en <= PWDATA[CT_IRQ_EN];
        thresh <= PWDATA[CT_THRESH +: 8];
        if (PWDATA[CT_CLR_ERR]) begin
          ovf <= 1'b0;
          udf <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_fifo_regs.sv
// Scoreboard bench for apb_fifo_regs: driver predicts each transfer from a queue model,
// a negedge monitor compares PRDATA/PSLVERR/wait states as transfers complete.
module tb_apb_fifo_regs;

  localparam int DEPTH = 16;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b0;
  logic [31:0] PADDR = '0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;
  logic        irq;

  always #5 PCLK = ~PCLK;

  apb_fifo_regs #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PREADY  (PREADY),
    .PRDATA  (PRDATA),
    .PSLVERR (PSLVERR),
    .irq     (irq)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] model_q[$];
  bit          m_ovf, m_udf, m_irq_en;
  logic [7:0]  m_thresh;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b1;
  int          wait_cnt = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] status_word();
    return {16'h0, 8'(model_q.size()), 4'h0, m_udf, m_ovf,
            model_q.size() == DEPTH, model_q.size() == 0};
  endfunction

  function automatic bit irq_model();
    return m_irq_en && (model_q.size() >= int'(m_thresh)) && (model_q.size() > 0);
  endfunction

  // Reference behaviour of one APB transfer, applied to the queue model.
  function automatic exp_t predict(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.rdata = '0;
    e.err   = 1'b0;
    e.waits = 0;
    if (addr[31:4] != 0) begin
      e.err = 1'b1;
    end else begin
      case (addr[3:0])
        4'h0: begin
          if (wr) begin
            if (model_q.size() == DEPTH) begin
              e.err = 1'b1;
              m_ovf = 1'b1;
            end else begin
              model_q.push_back(wdata);
            end
          end else if (model_q.size() == 0) begin
            e.err = 1'b1;
            m_udf = 1'b1;
          end else begin
            e.rdata = model_q.pop_front();
            e.waits = 1;
          end
        end
        4'h4: begin
          if (wr) e.err = 1'b1;
          else    e.rdata = status_word();
        end
        4'h8: begin
          if (wr) begin
            if (wdata[0]) model_q.delete();
            m_irq_en = wdata[1];
            if (wdata[2]) begin
              m_ovf = 1'b0;
              m_udf = 1'b0;
            end
            m_thresh = wdata[15:8];
          end else begin
            e.rdata = {16'h0, m_thresh, 6'h0, m_irq_en, 1'b0};
          end
        end
        default: e.err = 1'b1;
      endcase
    end
    return e;
  endfunction

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata, input string nm);
    exp_t e;
    int   n;
    e      = predict(wr, addr, wdata);
    e.name = nm;
    exp_q.push_back(e);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 0;
    forever begin
      @(negedge PCLK);
      if (PREADY) break;
      n++;
      if (n > 4) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: PREADY stayed low, required high within 4 cycles", nm);
        break;
      end
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic check_irq(input string nm);
    logic exp;
    exp = irq_model();
    @(posedge PCLK);
    @(negedge PCLK);
    chk(nm, irq, exp);
  endtask

  always @(negedge PCLK) begin
    if (mon_en && PSEL && PENABLE) begin
      if (!PREADY) begin
        wait_cnt++;
      end else begin
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk({mon_e.name, "_rdata"}, PRDATA, mon_e.rdata);
          chk({mon_e.name, "_err"}, PSLVERR, mon_e.err);
          chk({mon_e.name, "_waits"}, wait_cnt, mon_e.waits);
          $display("xfer %-12s wr=%0d addr=0x%02h prdata=0x%08h pslverr=%0d waits=%0d",
                   mon_e.name, PWRITE, PADDR[7:0], PRDATA, PSLVERR, wait_cnt);
        end
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushes;
    int r;

    m_ovf = 0; m_udf = 0; m_irq_en = 0; m_thresh = '0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b1;
    @(negedge PCLK);
    chk("rst_irq", irq, 1'b0);
    chk("rst_pslverr", PSLVERR, 1'b0);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_pready", PREADY, 1'b0);
    xfer(0, 32'h4, 0, "rst_status");

    xfer(1, 32'h0, 32'hA5, "push_a5");
    xfer(1, 32'h0, 32'h5A, "push_5a");
    xfer(0, 32'h0, 0, "pop_a5");
    xfer(0, 32'h0, 0, "pop_5a");
    xfer(0, 32'h4, 0, "status_emp");

    for (int i = 0; i < DEPTH; i++) xfer(1, 32'h0, $urandom, "fill");
    xfer(1, 32'h0, 32'hDEAD_BEEF, "push_full");
    xfer(0, 32'h4, 0, "status_ovf");
    xfer(1, 32'h8, 32'h4, "clr_err");
    xfer(0, 32'h4, 0, "status_full");
    for (int i = 0; i < DEPTH; i++) xfer(0, 32'h0, 0, "drain");

    xfer(0, 32'h0, 0, "pop_empty");
    xfer(0, 32'h4, 0, "status_udf");
    xfer(0, 32'hC, 0, "rd_unmapped");
    xfer(1, 32'h4, 32'hFFFF, "wr_status");
    xfer(0, 32'h14, 0, "rd_high_addr");
    xfer(1, 32'h10, 32'h1, "wr_high_addr");
    xfer(1, 32'h8, 32'h4, "clr_err2");

    xfer(1, 32'h8, 32'h0302, "ctrl_irq");
    xfer(1, 32'h0, 32'h11, "irq_push1");
    xfer(1, 32'h0, 32'h22, "irq_push2");
    check_irq("irq_below");
    xfer(1, 32'h0, 32'h33, "irq_push3");
    check_irq("irq_at_thr");
    xfer(0, 32'h0, 0, "irq_pop");
    check_irq("irq_dropped");
    xfer(1, 32'h0, 32'h44, "irq_push4");
    check_irq("irq_again");
    xfer(1, 32'h8, 32'h0303, "flush");
    check_irq("irq_flush");
    xfer(0, 32'h4, 0, "status_flush");
    xfer(0, 32'h8, 0, "ctrl_rd");

    xfer(1, 32'h8, {16'h0, 8'($urandom_range(0, 8)), 8'h02}, "ctrl_rand");
    pushes = 0;
    while (pushes < 40) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        xfer(1, 32'h0, $urandom, "rnd_push");
        pushes++;
      end else if (r < 9) begin
        xfer(0, 32'h0, 0, "rnd_pop");
      end else begin
        xfer(0, 32'h4, 0, "rnd_status");
      end
      if (r[0]) check_irq("rnd_irq");
    end

    // Abort a DATA read while the slave sits in its response cycle.
    xfer(1, 32'h0, 32'h77, "pre_rst_push");
    xfer(1, 32'h0, 32'h88, "pre_rst_push");
    repeat (2) @(posedge PCLK);
    mon_en = 1'b0;
    #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h0; PWRITE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PRESET = 1'b1;
    model_q.delete();
    m_ovf = 0; m_udf = 0; m_irq_en = 0; m_thresh = '0;
    @(negedge PCLK);
    chk("midrst_prdata", PRDATA, 32'h0);
    chk("midrst_pready", PREADY, 1'b0);
    chk("midrst_irq", irq, 1'b0);
    wait_cnt = 0;
    mon_en = 1'b1;
    xfer(0, 32'h4, 0, "midrst_status");
    xfer(0, 32'h8, 0, "midrst_ctrl");
    xfer(0, 32'h0, 0, "midrst_pop");

    repeat (3) @(posedge PCLK);
    chk("scoreboard_left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
